// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the op encodings, the FSM state type and the latency counter width.
// Imported by md_alu and md_ctrl.
package md_pkg;

    // Wide enough for latencies up to 16 cycles.
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Ops 0..3 occupy the multi-cycle unit; 4..7 never do.
    function automatic logic is_arith(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational 64-bit MULT/MULTU/DIV/DIVU result from latched operands.
// Latency: none (purely combinational); sampled by md_ctrl on its final count.
// Backpressure: none; hold=1 tells the caller to leave HI/LO untouched (divide by zero).
// Ports: op/a/b latched operands in; hi/lo result out; hold out.
module md_alu
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hold
);

    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // Signed divide is done on magnitudes so 0x80000000 / -1 falls out
    // naturally (magnitude 0x80000000, sign positive -> 0x80000000, rem 0)
    // without a special case or a trapping signed-overflow divide.
    assign div_signed = (op == OP_DIV);
    assign a_neg      = div_signed & a[31];
    assign b_neg      = div_signed & b[31];
    assign a_mag      = a_neg ? (32'd0 - a) : a;
    assign b_mag      = b_neg ? (32'd0 - b) : b;
    assign divisor    = (b == 32'd0) ? 32'd1 : b_mag;
    assign q_mag      = a_mag / divisor;
    assign r_mag      = a_mag % divisor;
    assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    // Remainder carries the dividend's sign.
    assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

    // Low 64 bits of a 64x64 product of sign-extended operands is the exact signed product.
    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    always_comb begin
        hi   = 32'd0;
        lo   = 32'd0;
        hold = 1'b1;
        case (op)
            OP_MULT:  begin hi = prod_s[63:32]; lo = prod_s[31:0]; hold = 1'b0; end
            OP_MULTU: begin hi = prod_u[63:32]; lo = prod_u[31:0]; hold = 1'b0; end
            OP_DIV,
            OP_DIVU:  begin hi = rem; lo = quot; hold = (b == 32'd0); end
            default:  begin hi = 32'd0; lo = 32'd0; hold = 1'b1; end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO owner and multiply/divide sequencer for the E stage; stalls D while busy.
// Latency: MULT_CYCLES / DIV_CYCLES edges after Start to HI/LO write; MTHI/MTLO write on the Start edge.
// Backpressure: Stall is combinational; Start while RUN is ignored.
// Ports: Clock, Reset (async low), Start/Op/A/B from E, MdUse_D from D; Busy, Stall, HI, LO out.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MdUse_D,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic [31:0]      alu_hi;
    logic [31:0]      alu_lo;
    logic             alu_hold;

    md_alu u_alu (
        .op   (op_r),
        .a    (a_r),
        .b    (b_r),
        .hi   (alu_hi),
        .lo   (alu_lo),
        .hold (alu_hold)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_r  <= 3'd0;
            a_r   <= 32'd0;
            b_r   <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (is_arith(Op)) begin
                            op_r  <= Op;
                            a_r   <= A;
                            b_r   <= B;
                            // Op[1] separates DIV/DIVU from MULT/MULTU.
                            cnt   <= Op[1] ? DIV_LOAD : MULT_LOAD;
                            state <= RUN;
                        end else if (Op == OP_MTHI) begin
                            HI <= A;
                        end else if (Op == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    // Start is deliberately not looked at here.
                    if (cnt == '0) begin
                        if (!alu_hold) begin
                            HI <= alu_hi;
                            LO <= alu_lo;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy  = (state == RUN);
    // A D-stage md instruction waits while the unit is busy or is being started this cycle.
    assign Stall = MdUse_D & (Busy | (Start & is_arith(Op)));

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        MdUse_D;
    logic        Busy;
    logic        Stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int total  = 0;
    int passed = 0;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .MdUse_D (MdUse_D),
        .Busy    (Busy),
        .Stall   (Stall),
        .HI      (HI),
        .LO      (LO)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] val);
        Start = 1'b1; Op = op; A = val; B = 32'd0;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;

        //           op    a             b             pre_hi        pre_lo        exp_hi        exp_lo
        vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'h00000005, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000005, 32'h00000006, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'h00000005, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd3, 32'h00000007, 32'h00000002, 32'h00000005, 32'h00000006, 32'h00000001, 32'h00000003};
        vecs[4]  = '{3'd2, 32'h00000009, 32'h00000000, 32'h00000011, 32'h00000022, 32'h00000011, 32'h00000022};
        vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000005, 32'h00000006, 32'h00000000, 32'h80000000};
        vecs[6]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000005, 32'h00000006, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{3'd3, 32'h00000009, 32'h00000000, 32'h000000AA, 32'h000000BB, 32'h000000AA, 32'h000000BB};
        vecs[8]  = '{3'd0, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000000C};
        vecs[9]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h00000005, 32'h00000006, 32'h40000000, 32'h00000000};
        vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h00000002, 32'h00000005, 32'h00000006, 32'h00000001, 32'h7FFFFFFF};

        Reset = 1'b0; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0; MdUse_D = 1'b0;
        tick();
        tick();

        // Reset state; Stall still combinational from MdUse_D/Start during reset.
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        MdUse_D = 1'b1; Start = 1'b1; Op = 3'd0;
        #1;
        chk("reset_stall_comb", 32'(Stall), 32'd1);
        Start = 1'b0; MdUse_D = 1'b0;
        #1;
        chk("reset_stall_idle", 32'(Stall), 32'd0);
        Reset = 1'b1;
        tick();

        // Table-driven arithmetic vectors, each with HI/LO preset via MTHI/MTLO.
        for (int i = 0; i < 11; i++) begin
            n = vecs[i].op[1] ? 10 : 5;
            mt(3'd4, vecs[i].pre_hi);
            mt(3'd5, vecs[i].pre_lo);
            chk($sformatf("v%0d_pre_hi", i), HI, vecs[i].pre_hi);
            chk($sformatf("v%0d_pre_lo", i), LO, vecs[i].pre_lo);
            Start = 1'b1; Op = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            tick();
            Start = 1'b0; A = 32'd0; B = 32'd0;
            for (int k = 0; k < n; k++) begin
                chk($sformatf("v%0d_busy_c%0d", i, k), 32'(Busy), 32'd1);
                tick();
            end
            chk($sformatf("v%0d_busy_end", i), 32'(Busy), 32'd0);
            chk($sformatf("v%0d_hi", i), HI, vecs[i].exp_hi);
            chk($sformatf("v%0d_lo", i), LO, vecs[i].exp_lo);
        end

        // Stall while MFLO sits in D during a MULT.
        MdUse_D = 1'b1; Start = 1'b1; Op = 3'd0; A = 32'd3; B = 32'd4;
        #1;
        chk("stall_on_start", 32'(Stall), 32'd1);
        tick();
        Start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_busy_c%0d", k), 32'(Stall), 32'd1);
            tick();
        end
        chk("stall_drop", 32'(Stall), 32'd0);
        chk("stall_mult_lo", LO, 32'd12);
        Start = 1'b1; Op = 3'd4; A = 32'h55;
        #1;
        chk("stall_mthi_none", 32'(Stall), 32'd0);
        Op = 3'd6;
        #1;
        chk("stall_op6_none", 32'(Stall), 32'd0);
        Start = 1'b0; MdUse_D = 1'b0;

        // MTHI: one-edge update, never busy.
        mt(3'd4, 32'h1234);
        chk("mthi_hi", HI, 32'h1234);
        chk("mthi_busy", 32'(Busy), 32'd0);
        chk("mthi_lo_kept", LO, 32'd12);

        // Op 6/7 with Start: no effect.
        mt(3'd6, 32'hDEAD);
        mt(3'd7, 32'hBEEF);
        chk("op67_hi", HI, 32'h1234);
        chk("op67_lo", LO, 32'd12);
        chk("op67_busy", 32'(Busy), 32'd0);

        // Start during RUN is ignored; first op's result and timing intact.
        Start = 1'b1; Op = 3'd1; A = 32'd3; B = 32'd5;
        tick();
        Start = 1'b0;
        tick();
        Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd7;
        tick();
        Start = 1'b1; Op = 3'd4; A = 32'hFFFF;
        tick();
        Start = 1'b0;
        chk("ignore_busy_mid", 32'(Busy), 32'd1);
        chk("ignore_hi_mid", HI, 32'h1234);
        tick();
        chk("ignore_busy_last", 32'(Busy), 32'd1);
        tick();
        chk("ignore_busy_end", 32'(Busy), 32'd0);
        chk("ignore_hi", HI, 32'd0);
        chk("ignore_lo", LO, 32'd15);
        tick();
        tick();
        chk("ignore_no_second", 32'(Busy), 32'd0);
        chk("ignore_lo_later", LO, 32'd15);

        // Reset mid-DIV: immediate clear, no late write after release.
        Start = 1'b1; Op = 3'd2; A = 32'd100; B = 32'd7;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        chk("rst_mid_busy_before", 32'(Busy), 32'd1);
        Reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(Busy), 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        tick();
        Reset = 1'b1;
        hold_hi = 32'd0;
        hold_lo = 32'd0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("rst_after_busy_c%0d", k), 32'(Busy), 32'd0);
        end
        chk("rst_after_hi", HI, hold_hi);
        chk("rst_after_lo", LO, hold_lo);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
